puf_response_demux16: RTL and testbench

Sequential 1-to-16 demultiplexing response collector for the arbiter PUF. It steps a 4-bit select through challenges 0..15 and fires a launch pulse for each race. After a programmable settle time it samples the single arbiter output bit and steers it into bit `sel` of a 16-bit response word. When all 16 bits are captured it publishes the word with a valid flag. It is the receiving counterpart of the 16:1 select tree that funnels PUF paths to one output.

---
 rtl/puf_response_demux16.sv | 112 +++++++++++
 tb/tb_puf_response_demux16.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/puf_response_demux16.sv
// Arbiter PUF response collector: walks sel 0..15, launches a race per
// bit, samples din after the settle time and publishes a 16-bit word.
module puf_response_demux16 #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        din,
  output logic [3:0]  sel,
  output logic        launch,
  output logic        busy,
  output logic [15:0] resp,
  output logic        valid
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CAPTURE
  } state_e;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic        launch_q, launch_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [15:0] resp_q, resp_d;
  logic [15:0] work_q, work_d;
  logic [7:0]  cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    launch_d = 1'b0;
    busy_d   = busy_q;
    valid_d  = valid_q;
    resp_d   = resp_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sel_d    = 4'd0;
          work_d   = 16'h0000;
          valid_d  = 1'b0;
          busy_d   = 1'b1;
          launch_d = 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CAPTURE: begin
        work_d[sel_q] = din;
        // Publish straight from work_d so bit 15 lands in the same edge.
        if (sel_q == 4'd15) begin
          resp_d  = work_d;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          sel_d    = sel_q + 4'd1;
          launch_d = 1'b1;
          state_d  = LAUNCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 4'd0;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      resp_q   <= 16'h0000;
      work_q   <= 16'h0000;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      launch_q <= launch_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      resp_q   <= resp_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sel    = sel_q;
  assign launch = launch_q;
  assign busy   = busy_q;
  assign resp   = resp_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_puf_response_demux16.sv
// Bench for puf_response_demux16: cycle-exact timing checks plus a
// response scoreboard, on settle times of 4 and 1.
module tb_puf_response_demux16;

  logic        clk;
  logic        rst_n;
  logic        start_b;
  logic        din_b;
  bit          use1;

  logic        start0, start1;
  logic [3:0]  sel0, sel1;
  logic        launch0, launch1;
  logic        busy0, busy1;
  logic [15:0] resp0, resp1;
  logic        valid0, valid1;

  logic [3:0]  o_sel;
  logic        o_launch;
  logic        o_busy;
  logic [15:0] o_resp;
  logic        o_valid;

  int          errors;
  int          checks;
  logic [15:0] exp_q[$];
  logic [15:0] model_resp;
  logic        pv;

  assign start0 = start_b & ~use1;
  assign start1 = start_b & use1;

  assign o_sel    = use1 ? sel1 : sel0;
  assign o_launch = use1 ? launch1 : launch0;
  assign o_busy   = use1 ? busy1 : busy0;
  assign o_resp   = use1 ? resp1 : resp0;
  assign o_valid  = use1 ? valid1 : valid0;

  puf_response_demux16 #(.SETTLE_CYCLES(4)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start0),
    .din    (din_b),
    .sel    (sel0),
    .launch (launch0),
    .busy   (busy0),
    .resp   (resp0),
    .valid  (valid0)
  );

  puf_response_demux16 #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start1),
    .din    (din_b),
    .sel    (sel1),
    .launch (launch1),
    .busy   (busy1),
    .resp   (resp1),
    .valid  (valid1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (o_valid && !pv) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        chk("sb_resp", o_resp, exp_q.pop_front());
      end
    end
    pv <= o_valid;
  end

  // mode 0: pat at capture, noise elsewhere
  // mode 1: toggle, 0 at capture; mode 2: constant pat[0]
  // mode 3: 1 only on the edge before capture
  task automatic run(input int s, input logic [15:0] pat,
                     input int mode, input bit extra,
                     input bit hold);
    int p;
    int k;
    bit cap;
    logic tog;
    logic [15:0] expv;
    p = s + 2;
    if (mode == 1 || mode == 3) expv = 16'h0000;
    else if (mode == 2) expv = {16{pat[0]}};
    else expv = pat;
    start_b = 1'b1;
    din_b = 1'b0;
    step();
    exp_q.push_back(expv);
    if (!hold) start_b = 1'b0;
    chk("e0_busy", o_busy, 1);
    chk("e0_valid", o_valid, 0);
    chk("e0_launch", o_launch, 1);
    chk("e0_sel", o_sel, 0);
    chk("e0_resp", o_resp, model_resp);
    tog = 1'b0;
    for (int n = 1; n <= 16 * p; n++) begin
      cap = (n % p) == 0;
      k = n / p - 1;
      tog = ~tog;
      case (mode)
        0: din_b = cap ? pat[k] : 1'($urandom_range(0, 1));
        1: din_b = cap ? 1'b0 : tog;
        2: din_b = pat[0];
        default: din_b = ((n + 1) % p) == 0;
      endcase
      if (extra) start_b = (n == 10 || n == 50);
      step();
      chk("launch", o_launch, (n % p == 0) && (n < 16 * p));
      chk("sel", o_sel, (n / p > 15) ? 15 : n / p);
      chk("busy", o_busy, n < 16 * p);
      chk("valid", o_valid, n == 16 * p);
      chk("resp", o_resp, (n == 16 * p) ? expv : model_resp);
    end
    model_resp = expv;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    pv = 1'b0;
    use1 = 1'b0;
    rst_n = 1'b0;
    start_b = 1'b0;
    din_b = 1'b0;
    model_resp = 16'h0000;
    repeat (2) step();
    chk("rst_sel", o_sel, 0);
    chk("rst_launch", o_launch, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_resp", o_resp, 0);
    chk("rst1_busy", busy1, 0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_busy", o_busy, 0);

    run(4, 16'hA5C3, 0, 1'b0, 1'b0);
    run(4, 16'h3C5A, 0, 1'b1, 1'b0);
    run(4, 16'h0000, 1, 1'b0, 1'b0);
    run(4, 16'h0000, 2, 1'b0, 1'b1);
    run(4, 16'hFFFF, 2, 1'b0, 1'b1);
    start_b = 1'b0;
    repeat (3) step();
    chk("b2b_idle", o_busy, 0);

    use1 = 1'b1;
    model_resp = 16'h0000;
    run(1, 16'hFFFF, 2, 1'b0, 1'b0);
    run(1, 16'h0000, 3, 1'b0, 1'b0);
    repeat (2) step();

    use1 = 1'b0;
    start_b = 1'b1;
    din_b = 1'b1;
    step();
    start_b = 1'b0;
    repeat (44) step();
    chk("mid_busy", o_busy, 1);
    chk("mid_sel", o_sel, 7);
    rst_n = 1'b0;
    #1;
    chk("arst_sel", o_sel, 0);
    chk("arst_launch", o_launch, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_resp", o_resp, 0);
    #1;
    rst_n = 1'b1;
    repeat (10) step();
    chk("post_busy", o_busy, 0);
    chk("post_launch", o_launch, 0);
    chk("post_sel", o_sel, 0);
    chk("post_valid", o_valid, 0);
    chk("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
